load_store_unit: RTL

- Initiator side of the data-memory interface.
- Accepts load/store requests from the execute/memory pipeline stage and translates them into doubleword accesses on the data memory port (mem_read/mem_write, 1-cycle registered read data).
- Byte/half/word loads: extracts and sign- or zero-extends the addressed lanes.
- Sub-doubleword stores: read-modify-write, because the memory writes whole 64-bit doublewords only.
- Rejects misaligned and out-of-range accesses with an error response instead of letting them reach memory.

---
 rtl/lsu_pkg.sv | 20 ++
 rtl/lsu_align.sv | 54 +++++
 rtl/load_store_unit.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// Shared constants for the load/store unit: access-size encodings, FSM state codes
// and the default data-memory size.
package lsu_pkg;

  localparam int MEM_BYTES_DEFAULT = 8192;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  typedef logic [2:0] lsu_state_t;

  localparam lsu_state_t ST_IDLE    = 3'd0;
  localparam lsu_state_t ST_ISSUE   = 3'd1;
  localparam lsu_state_t ST_CAPTURE = 3'd2;
  localparam lsu_state_t ST_WRITE   = 3'd3;
  localparam lsu_state_t ST_RESP    = 3'd4;

endpackage

// File: rtl/lsu_align.sv
// Lane steering for the load/store unit: load extract with sign/zero extension,
// and byte merge of store data into a read doubleword.
module lsu_align
  import lsu_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [1:0]      size_i,
  input  logic            unsigned_i,
  input  logic [2:0]      offset_i,
  input  logic [XLEN-1:0] rdata_i,
  input  logic [XLEN-1:0] wdata_i,
  output logic [XLEN-1:0] load_data_o,
  output logic [XLEN-1:0] merge_data_o
);

  logic [XLEN-1:0] rd_shift;
  logic [XLEN-1:0] wd_shift;
  logic [7:0]      lanes;
  logic [7:0]      be;

  always_comb begin
    rd_shift = rdata_i >> {offset_i, 3'b000};
    wd_shift = wdata_i << {offset_i, 3'b000};
    load_data_o = rd_shift;
    lanes = 8'hFF;
    case (size_i)
      SZ_B: begin
        lanes = 8'h01;
        load_data_o = unsigned_i ? {{(XLEN-8){1'b0}}, rd_shift[7:0]}
                                 : {{(XLEN-8){rd_shift[7]}}, rd_shift[7:0]};
      end
      SZ_H: begin
        lanes = 8'h03;
        load_data_o = unsigned_i ? {{(XLEN-16){1'b0}}, rd_shift[15:0]}
                                 : {{(XLEN-16){rd_shift[15]}}, rd_shift[15:0]};
      end
      SZ_W: begin
        lanes = 8'h0F;
        load_data_o = unsigned_i ? {{(XLEN-32){1'b0}}, rd_shift[31:0]}
                                 : {{(XLEN-32){rd_shift[31]}}, rd_shift[31:0]};
      end
      default: begin
        lanes = 8'hFF;
        load_data_o = rd_shift;
      end
    endcase
    be = lanes << offset_i;
    for (int k = 0; k < 8; k++) begin
      merge_data_o[8*k +: 8] = be[k] ? wd_shift[8*k +: 8] : rdata_i[8*k +: 8];
    end
  end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory initiator: turns load/store requests into doubleword accesses,
// with read-modify-write for partial stores. Optional LSU_PERF_CNT_EN adds counters.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int MEM_BYTES = MEM_BYTES_DEFAULT,
  parameter int XLEN      = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_is_store,
  input  logic [1:0]      req_size,
  input  logic            req_unsigned,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            resp_valid,
  output logic [XLEN-1:0] resp_rdata,
  output logic            resp_err,
  output logic [XLEN-1:0] mem_address,
  output logic [XLEN-1:0] mem_write_data,
  output logic            mem_write,
  output logic            mem_read,
  input  logic [XLEN-1:0] mem_read_data
`ifdef LSU_PERF_CNT_EN
  ,
  output logic [31:0]     perf_loads,
  output logic [31:0]     perf_stores,
  output logic [31:0]     perf_errors
`endif
);

  lsu_state_t      state_q, state_d;
  logic            is_store_q, unsigned_q, err_q;
  logic [1:0]      size_q;
  logic [XLEN-1:0] addr_q, wdata_q, data_q, rdata_q;
  logic [XLEN-1:0] load_data, merge_data;
  logic [XLEN:0]   end_addr;
  logic            misaligned, req_err, dbl_store;

  // End address is one bit wider so addresses near 2^XLEN cannot wrap into range.
  always_comb begin
    case (req_size)
      SZ_B:    misaligned = 1'b0;
      SZ_H:    misaligned = req_addr[0];
      SZ_W:    misaligned = |req_addr[1:0];
      default: misaligned = |req_addr[2:0];
    endcase
    end_addr = {1'b0, req_addr} + ((XLEN+1)'(1) << req_size);
    req_err  = misaligned || (end_addr > (XLEN+1)'(MEM_BYTES));
  end

  assign dbl_store = is_store_q && (size_q == SZ_D);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (req_valid) state_d = req_err ? ST_RESP : ST_ISSUE;
      ST_ISSUE:   state_d = dbl_store ? ST_RESP : ST_CAPTURE;
      ST_CAPTURE: state_d = is_store_q ? ST_WRITE : ST_RESP;
      ST_WRITE:   state_d = ST_RESP;
      ST_RESP:    state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  lsu_align #(.XLEN(XLEN)) u_align (
    .size_i       (size_q),
    .unsigned_i   (unsigned_q),
    .offset_i     (addr_q[2:0]),
    .rdata_i      (mem_read_data),
    .wdata_i      (wdata_q),
    .load_data_o  (load_data),
    .merge_data_o (merge_data)
  );

  // rdata_q only changes on the edge entering RESP, so it holds between responses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      is_store_q <= 1'b0;
      unsigned_q <= 1'b0;
      err_q      <= 1'b0;
      size_q     <= SZ_B;
      addr_q     <= '0;
      wdata_q    <= '0;
      data_q     <= '0;
      rdata_q    <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            is_store_q <= req_is_store;
            unsigned_q <= req_unsigned;
            size_q     <= req_size;
            addr_q     <= req_addr;
            wdata_q    <= req_wdata;
            err_q      <= req_err;
            if (req_err) rdata_q <= '0;
          end
        end
        ST_ISSUE:   if (dbl_store) rdata_q <= '0;
        ST_CAPTURE: begin
          if (is_store_q) data_q  <= merge_data;
          else            rdata_q <= load_data;
        end
        ST_WRITE:   rdata_q <= '0;
        default:    ;
      endcase
    end
  end

  assign req_ready      = (state_q == ST_IDLE);
  assign resp_valid     = (state_q == ST_RESP);
  assign resp_err       = (state_q == ST_RESP) && err_q;
  assign resp_rdata     = rdata_q;
  assign mem_address    = {addr_q[XLEN-1:3], 3'b000};
  assign mem_read       = (state_q == ST_ISSUE) && !dbl_store;
  assign mem_write      = ((state_q == ST_ISSUE) && dbl_store) || (state_q == ST_WRITE);
  assign mem_write_data = !mem_write ? '0 : ((state_q == ST_WRITE) ? data_q : wdata_q);

`ifdef LSU_PERF_CNT_EN
  logic [31:0] perf_loads_q, perf_stores_q, perf_errors_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_loads_q  <= '0;
      perf_stores_q <= '0;
      perf_errors_q <= '0;
    end else if (state_q == ST_RESP) begin
      if (err_q)           perf_errors_q <= perf_errors_q + 32'd1;
      else if (is_store_q) perf_stores_q <= perf_stores_q + 32'd1;
      else                 perf_loads_q  <= perf_loads_q + 32'd1;
    end
  end

  assign perf_loads  = perf_loads_q;
  assign perf_stores = perf_stores_q;
  assign perf_errors = perf_errors_q;
`endif

endmodule
